uart_rx_buffer: RTL
===================

Name: uart_rx_buffer

Overview:
Receive datapath directly downstream of the UART RX FSM controller. Deserialises the sampled Rx line under the controller's shift_en strobe. On done, commits the assembled frame into a small first-word-fall-through FIFO. On err, records a framing error. Exposes a pop interface and sticky status flags to the APB register wrapper.

Parameters:
N, 8, data bits per frame; must match the RX controller's N.
DEPTH, 4, FIFO entries; power of two, 2 to 16.
AW, log2(DEPTH), FIFO address width; derived, not overridden.

Ports:
clk  in  1  system clock
arst_n  in  1  asynchronous active-low reset
rst  in  1  synchronous clear of the whole block (same source as the controller's rst)
rx  in  1  synchronised serial line, the same signal the controller samples
shift_en  in  1  controller strobe: sample rx into the shift register
done  in  1  controller strobe: valid stop bit, frame complete
err  in  1  controller strobe: stop bit low, framing error
rd_en  in  1  pop request from the APB side
clr_err  in  1  single-cycle pulse that clears overrun and frm_err
rd_data  out  N  FIFO head, valid while empty=0
empty  out  1  FIFO holds no entries
full  out  1  FIFO holds DEPTH entries
level  out  AW+1  number of entries, 0..DEPTH
overrun  out  1  sticky: a completed frame was dropped because the FIFO was full
frm_err  out  1  sticky: a framing error was seen
irq  out  1  ~empty | overrun | frm_err, registered

Behaviour:
- Reset (arst_n=0, or rst=1 at a clock edge):
  - shift register = 0, FIFO pointers = 0.
  - empty=1, full=0, level=0, overrun=0, frm_err=0, irq=0, rd_data=0.
- Shift register sr[N-1:0], LSB first:
  - On shift_en, sr <= {rx, sr[N-1:1]}.
  - After N shifts, sr holds the byte with the first-received bit in sr[0].
- Push on done:
  - If not full, write sr to wr_ptr and increment wr_ptr. The write takes effect the next cycle (empty falls, level increments).
  - If full and no pop in the same cycle, drop the frame and set overrun.
- done and shift_en are mutually exclusive from the controller. If both are asserted, the push uses the pre-shift sr and the shift still occurs.
- err: set frm_err; no push; sr is left unchanged.
- Pop: rd_en with empty=0 advances rd_ptr. rd_data is combinational from the FIFO head (FWFT): a pushed entry is visible on rd_data the cycle after done. rd_en while empty is ignored, with no pointer or level change.
- Simultaneous push and pop:
  - Not empty and not full: both happen, level unchanged.
  - Full: pop frees a slot, push succeeds, no overrun.
  - Empty: push only, rd_en ignored.
- Pointers are AW+1 bits and wrap modulo 2*DEPTH.
  - empty = (wr_ptr == rd_ptr).
  - full = (MSBs differ, lower bits equal).
  - level = wr_ptr - rd_ptr (AW+1-bit modulo arithmetic).
- Sticky flags: set in the cycle after the causing event. If set and clr_err coincide, set wins.
- irq is registered from next-state values, so it rises in the same cycle empty falls.
- rst mid-frame: sr cleared; the partial frame is lost. FIFO contents are discarded.

Decomposition:
- Shared include uart_defs: default frame width (8), default RX FIFO depth (4), clog2 helper.
- One natural sub-module: sync_fifo (parameter W, DEPTH). It contains the memory, pointers, and full/empty/level logic. uart_rx_buffer holds the shift register, sticky flags, irq, and push/drop decision.
- sync_fifo is reusable by the TX path.

Test Plan:
- Frame 0xA5: shift_en with rx = 1,0,1,0,0,1,0,1, then done -> next cycle empty=0, level=1, rd_data=0xA5, irq=1. rd_en one cycle -> empty=1, level=0.
- Fill 4 frames 0x01..0x04, then a 5th frame 0x05 -> full=1, overrun=1, level=4. Pops return 01, 02, 03, 04; 0x05 is never seen.
- With FIFO full, done and rd_en in the same cycle -> no overrun, level stays 4. Next four pops return 02, 03, 04, then the new frame.
- err strobe after 8 shifts -> frm_err=1, level unchanged, irq=1. clr_err -> frm_err=0. clr_err coincident with a new err -> frm_err stays 1.
- Wrap-around: push and pop 10 frames (0x10..0x19) one at a time with DEPTH=4 -> each pop matches its push; empty/full correct across the pointer MSB flip.
- rst asserted after 3 shifts with 2 entries queued -> level=0, empty=1, flags 0. Next full frame 0x3C reads back exactly 0x3C.

Source files
------------

// File: rtl/uart_rx_buffer_pkg.sv
// Shared UART receive-path defaults and sizing helper.
package uart_rx_buffer_pkg;

  localparam int unsigned UART_N_DEF     = 8;
  localparam int unsigned UART_DEPTH_DEF = 4;

  // Smallest r such that 2**r >= v
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_rx_buffer_if.sv
// Pop/status bus between the RX buffer and the APB register wrapper.
interface uart_rx_buffer_if
  import uart_rx_buffer_pkg::*;
#(
  parameter int unsigned N     = UART_N_DEF,
  parameter int unsigned DEPTH = UART_DEPTH_DEF
);
  localparam int unsigned AW = clog2(DEPTH);

  logic          rd_en;
  logic          clr_err;
  logic [N-1:0]  rd_data;
  logic          empty;
  logic          full;
  logic [AW:0]   level;
  logic          overrun;
  logic          frm_err;
  logic          irq;

  modport master (
    output rd_en, clr_err,
    input  rd_data, empty, full, level, overrun, frm_err, irq
  );

  modport slave (
    input  rd_en, clr_err,
    output rd_data, empty, full, level, overrun, frm_err, irq
  );
endinterface

// File: rtl/uart_rx_buffer_sync_fifo.sv
// First-word-fall-through FIFO with AW+1-bit wrapping pointers; shared with the TX path.
module sync_fifo
  import uart_rx_buffer_pkg::*;
#(
  parameter int unsigned W     = UART_N_DEF,
  parameter int unsigned DEPTH = UART_DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     arst_n,
  input  logic                     clr,
  input  logic                     wr_en,
  input  logic [W-1:0]             wr_data,
  input  logic                     rd_en,
  output logic [W-1:0]             rd_data,
  output logic                     empty,
  output logic                     full,
  output logic [clog2(DEPTH):0]    level,
  output logic                     empty_next_c
);
  localparam int unsigned AW = clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [W-1:0]  mem_q [DEPTH];
  logic          push_ok, pop_ok;

  // A pop at full frees the slot the coincident push needs
  always_comb begin
    pop_ok  = rd_en & ~empty;
    push_ok = wr_en & (~full | pop_ok);
    wr_d    = wr_q + PW'(push_ok);
    rd_d    = rd_q + PW'(pop_ok);
    if (clr) begin
      wr_d = '0;
      rd_d = '0;
    end
  end

  // Pointer registers
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage; cleared on reset so the head never reads unknown data
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (push_ok && !clr) begin
      mem_q[wr_q[AW-1:0]] <= wr_data;
    end
  end

  assign empty        = (wr_q == rd_q);
  assign full         = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign level        = wr_q - rd_q;
  assign rd_data      = empty ? '0 : mem_q[rd_q[AW-1:0]];
  assign empty_next_c = (wr_d == rd_d);

endmodule

// File: rtl/uart_rx_buffer.sv
// UART RX datapath: LSB-first deserialiser, frame FIFO, sticky error flags and irq.
module uart_rx_buffer
  import uart_rx_buffer_pkg::*;
#(
  parameter int unsigned N     = UART_N_DEF,
  parameter int unsigned DEPTH = UART_DEPTH_DEF
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             rst,
  input  logic             rx,
  input  logic             shift_en,
  input  logic             done,
  input  logic             err,
  uart_rx_buffer_if.slave  apb
);
  logic [N-1:0] sr_q, sr_d;
  logic         overrun_q, overrun_d;
  logic         frm_err_q, frm_err_d;
  logic         irq_q, irq_d;
  logic         drop;
  logic         fifo_empty_next;

  // Frame store; push always takes the pre-shift register
  sync_fifo #(
    .W     (N),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk          (clk),
    .arst_n       (arst_n),
    .clr          (rst),
    .wr_en        (done),
    .wr_data      (sr_q),
    .rd_en        (apb.rd_en),
    .rd_data      (apb.rd_data),
    .empty        (apb.empty),
    .full         (apb.full),
    .level        (apb.level),
    .empty_next_c (fifo_empty_next)
  );

  // Next-state for shifter and flags; a set beats a coincident clear
  always_comb begin
    drop      = done & apb.full & ~apb.rd_en;
    sr_d      = sr_q;
    if (shift_en) sr_d = {rx, sr_q[N-1:1]};
    overrun_d = drop | (overrun_q & ~apb.clr_err);
    frm_err_d = err  | (frm_err_q & ~apb.clr_err);
    irq_d     = ~fifo_empty_next | overrun_d | frm_err_d;
    if (rst) begin
      sr_d      = '0;
      overrun_d = 1'b0;
      frm_err_d = 1'b0;
      irq_d     = 1'b0;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      sr_q      <= '0;
      overrun_q <= 1'b0;
      frm_err_q <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      sr_q      <= sr_d;
      overrun_q <= overrun_d;
      frm_err_q <= frm_err_d;
      irq_q     <= irq_d;
    end
  end

  assign apb.overrun = overrun_q;
  assign apb.frm_err = frm_err_q;
  assign apb.irq     = irq_q;

endmodule
